// File: rtl/dcache_port_arbiter.sv
// Single-port dcache arbiter: store-drain writes vs. load reads, fixed latency.
// Ports: clk/resetb, SB_* store head, Lsq_* load req, DCE_* handshakes, Mem_* port.
module dcache_port_arbiter #(
  parameter int WRITE_LAT  = 4,
  parameter int READ_LAT   = 4,
  parameter int STARVE_MAX = 3,
  parameter int TAG_W      = 6
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             SB_DataValid,
  input  logic [31:0]      SB_AddrDmem,
  input  logic [31:0]      SB_DataDmem,
  input  logic             SB_Full,
  output logic             DCE_WriteBusy,
  output logic             DCE_WriteDone,
  input  logic             Lsq_ReadReq,
  input  logic [31:0]      Lsq_ReadAddr,
  input  logic [TAG_W-1:0] Lsq_ReadTag,
  output logic             DCE_ReadBusy,
  output logic             DCE_ReadDone,
  output logic [31:0]      DCE_ReadData,
  output logic [TAG_W-1:0] DCE_ReadTag,
  input  logic             Cdb_Flush,
  output logic             Mem_En,
  output logic             Mem_We,
  output logic [31:0]      Mem_Addr,
  output logic [31:0]      Mem_WData,
  input  logic [31:0]      Mem_RData
);

  localparam int MAXL = (WRITE_LAT > READ_LAT) ? WRITE_LAT : READ_LAT;
  localparam int CW   = $clog2(MAXL + 1);
  localparam int SW   = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;

  localparam logic [CW-1:0] WCNT = CW'(WRITE_LAT - 1);
  localparam logic [CW-1:0] RCNT = CW'(READ_LAT - 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] streak;
  logic          killed;

  logic idle;
  logic last;
  logic wgrant;
  logic rgrant;
  logic acc_w;
  logic acc_r;
  logic killed_nx;

  assign idle = (state == S_IDLE);
  assign last = (cnt == '0);

  // Stores win when the buffer is full, loads have had their streak,
  // or there is no load competing.
  assign wgrant = SB_DataValid &
                  (SB_Full | (streak == SMAX) | !Lsq_ReadReq);
  assign rgrant = Lsq_ReadReq & !wgrant;

  assign acc_w = idle & wgrant & !resetb;
  assign acc_r = idle & rgrant & !resetb;

  assign DCE_WriteBusy = !acc_w;
  assign DCE_ReadBusy  = !acc_r;

  // An operation cut short by reset is dropped: no enable, no done.
  assign DCE_WriteDone = (state == S_WRITE) & last & !resetb;
  assign Mem_En = ((state == S_WRITE) | (state == S_READ)) & !resetb;
  assign Mem_We = (state == S_WRITE) & !resetb;

  // A flush in the final read cycle still suppresses the completion.
  assign killed_nx = killed | Cdb_Flush;

  always_ff @(posedge clk) begin
    if (resetb) begin
      state        <= S_IDLE;
      cnt          <= '0;
      streak       <= '0;
      killed       <= 1'b0;
      DCE_ReadDone <= 1'b0;
      DCE_ReadData <= '0;
      DCE_ReadTag  <= '0;
      Mem_Addr     <= '0;
      Mem_WData    <= '0;
    end else begin
      DCE_ReadDone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wgrant) begin
            Mem_Addr  <= SB_AddrDmem;
            Mem_WData <= SB_DataDmem;
            streak    <= '0;
            cnt       <= WCNT;
            state     <= S_WRITE;
          end else if (rgrant) begin
            Mem_Addr    <= Lsq_ReadAddr;
            DCE_ReadTag <= Lsq_ReadTag;
            killed      <= Cdb_Flush;
            cnt         <= RCNT;
            state       <= S_READ;
            if (!SB_DataValid)
              streak <= '0;
            else if (streak != SMAX)
              streak <= streak + SW'(1);
          end
        end
        S_WRITE: begin
          if (last)
            state <= S_IDLE;
          else
            cnt <= cnt - CW'(1);
        end
        S_READ: begin
          killed <= killed_nx;
          if (last) begin
            DCE_ReadData <= Mem_RData;
            DCE_ReadDone <= !killed_nx;
            state        <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Testbench for dcache_port_arbiter: scenario tasks with scoreboard queues.
// Expected writes/reads/grant orders are queued at stimulus, popped at output.
module tb_dcache_port_arbiter;

  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          resetb = 1'b1;
  logic          SB_DataValid = 1'b0;
  logic [31:0]   SB_AddrDmem = '0;
  logic [31:0]   SB_DataDmem = '0;
  logic          SB_Full = 1'b0;
  logic          DCE_WriteBusy;
  logic          DCE_WriteDone;
  logic          Lsq_ReadReq = 1'b0;
  logic [31:0]   Lsq_ReadAddr = '0;
  logic [TW-1:0] Lsq_ReadTag = '0;
  logic          DCE_ReadBusy;
  logic          DCE_ReadDone;
  logic [31:0]   DCE_ReadData;
  logic [TW-1:0] DCE_ReadTag;
  logic          Cdb_Flush = 1'b0;
  logic          Mem_En;
  logic          Mem_We;
  logic [31:0]   Mem_Addr;
  logic [31:0]   Mem_WData;
  logic [31:0]   Mem_RData = '0;

  dcache_port_arbiter #(
    .WRITE_LAT(4), .READ_LAT(4), .STARVE_MAX(3), .TAG_W(TW)
  ) dut (
    .clk(clk), .resetb(resetb),
    .SB_DataValid(SB_DataValid), .SB_AddrDmem(SB_AddrDmem),
    .SB_DataDmem(SB_DataDmem), .SB_Full(SB_Full),
    .DCE_WriteBusy(DCE_WriteBusy), .DCE_WriteDone(DCE_WriteDone),
    .Lsq_ReadReq(Lsq_ReadReq), .Lsq_ReadAddr(Lsq_ReadAddr),
    .Lsq_ReadTag(Lsq_ReadTag), .DCE_ReadBusy(DCE_ReadBusy),
    .DCE_ReadDone(DCE_ReadDone), .DCE_ReadData(DCE_ReadData),
    .DCE_ReadTag(DCE_ReadTag), .Cdb_Flush(Cdb_Flush),
    .Mem_En(Mem_En), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
    .Mem_WData(Mem_WData), .Mem_RData(Mem_RData)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wexp_t;

  typedef struct packed {
    logic [31:0]   d;
    logic [TW-1:0] t;
  } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  byte   gq[$];

  int n_checks = 0;
  int n_fail = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetb = 1'b1;
    SB_DataValid = 1'b1;
    Lsq_ReadReq = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    n_checks++;
    if ({DCE_WriteBusy, DCE_ReadBusy, Mem_En, Mem_We,
         DCE_WriteDone, DCE_ReadDone} !== 6'b110000) begin
      n_fail++;
      $display("FAIL rst_ctl: got %b want 110000",
        {DCE_WriteBusy, DCE_ReadBusy, Mem_En, Mem_We,
         DCE_WriteDone, DCE_ReadDone});
    end
    n_checks++;
    if ({Mem_Addr, Mem_WData, DCE_ReadData, DCE_ReadTag} !== '0) begin
      n_fail++;
      $display("FAIL rst_data: got %h %h %h %h want 0",
        Mem_Addr, Mem_WData, DCE_ReadData, DCE_ReadTag);
    end
    cyc();
    resetb = 1'b0;
    SB_DataValid = 1'b0;
    Lsq_ReadReq = 1'b0;
    cyc();
    @(negedge clk);
    n_checks++;
    if ({DCE_WriteBusy, DCE_ReadBusy, Mem_En} !== 3'b110) begin
      n_fail++;
      $display("FAIL idle_norq: got %b want 110",
        {DCE_WriteBusy, DCE_ReadBusy, Mem_En});
    end
  endtask

  task automatic test_write();
    wexp_t w;
    cyc();
    SB_DataValid = 1'b1;
    SB_AddrDmem = 32'h100;
    SB_DataDmem = 32'hDEADBEEF;
    wq.push_back('{a: 32'h100, d: 32'hDEADBEEF});
    @(negedge clk);
    n_checks++;
    if (DCE_WriteBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_accept: busy %b want 0", DCE_WriteBusy);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 1) begin
        SB_DataValid = 1'b0;
        SB_AddrDmem = 32'hFFFF_0000;
        SB_DataDmem = 32'h0BAD_0BAD;
      end
      @(negedge clk);
      n_checks++;
      if ({Mem_En, Mem_We} !== 2'b11 || Mem_Addr !== 32'h100 ||
          Mem_WData !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL wr_mem c%0d: en/we %b%b a %h d %h want 11 100 deadbeef",
          i, Mem_En, Mem_We, Mem_Addr, Mem_WData);
      end
      n_checks++;
      if (DCE_WriteDone !== (i == 4)) begin
        n_fail++;
        $display("FAIL wr_done c%0d: got %b want %b",
          i, DCE_WriteDone, (i == 4));
      end
      if (DCE_WriteDone === 1'b1 && wq.size() > 0) begin
        w = wq.pop_front();
        n_checks++;
        if (Mem_Addr !== w.a || Mem_WData !== w.d) begin
          n_fail++;
          $display("FAIL wr_sb: got %h/%h want %h/%h",
            Mem_Addr, Mem_WData, w.a, w.d);
        end
      end
    end
    n_checks++;
    if (wq.size() != 0) begin
      n_fail++;
      $display("FAIL wr_pending: %0d left want 0", wq.size());
      wq.delete();
    end
    cyc();
    SB_DataValid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({DCE_WriteBusy, Mem_En, DCE_WriteDone} !== 3'b000 ||
        Mem_Addr !== 32'h100) begin
      n_fail++;
      $display("FAIL wr_c5: busy/en/done %b a %h want 000 100",
        {DCE_WriteBusy, Mem_En, DCE_WriteDone}, Mem_Addr);
    end
    #1;
    SB_DataValid = 1'b0;
  endtask

  task automatic test_read();
    rexp_t r;
    cyc();
    Lsq_ReadReq = 1'b1;
    Lsq_ReadAddr = 32'h200;
    Lsq_ReadTag = 6'd5;
    Mem_RData = 32'hBAD0BAD0;
    rq.push_back('{d: 32'h1234, t: 6'd5});
    @(negedge clk);
    n_checks++;
    if ({DCE_ReadBusy, DCE_WriteBusy} !== 2'b01) begin
      n_fail++;
      $display("FAIL rd_accept: r/w busy %b want 01",
        {DCE_ReadBusy, DCE_WriteBusy});
    end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 1) begin
        Lsq_ReadReq = 1'b0;
        Lsq_ReadTag = 6'd0;
      end
      Mem_RData = (i == 4) ? 32'h1234 : 32'hBAD0BAD0;
      @(negedge clk);
      n_checks++;
      if ({Mem_En, Mem_We, DCE_ReadDone} !== 3'b100 ||
          Mem_Addr !== 32'h200) begin
        n_fail++;
        $display("FAIL rd_mem c%0d: en/we/done %b a %h want 100 200",
          i, {Mem_En, Mem_We, DCE_ReadDone}, Mem_Addr);
      end
    end
    cyc();
    Mem_RData = 32'hBAD0BAD0;
    @(negedge clk);
    n_checks++;
    if (DCE_ReadDone !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_done: got %b want 1", DCE_ReadDone);
    end
    if (rq.size() > 0) begin
      r = rq.pop_front();
      n_checks++;
      if (DCE_ReadData !== r.d || DCE_ReadTag !== r.t) begin
        n_fail++;
        $display("FAIL rd_sb: got %h/%0d want %h/%0d",
          DCE_ReadData, DCE_ReadTag, r.d, r.t);
      end
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (DCE_ReadDone !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_pulse: got %b want 0", DCE_ReadDone);
    end
  endtask

  task automatic test_starvation();
    byte g;
    byte e;
    gq = '{"R", "R", "R", "W", "R", "R", "R", "W"};
    cyc();
    SB_DataValid = 1'b1;
    Lsq_ReadReq = 1'b1;
    for (int c = 0; c < 100 && gq.size() > 0; c++) begin
      @(negedge clk);
      if (!DCE_WriteBusy || !DCE_ReadBusy) begin
        g = !DCE_WriteBusy ? "W" : "R";
        e = gq.pop_front();
        n_checks++;
        if (g !== e || (!DCE_WriteBusy && !DCE_ReadBusy)) begin
          n_fail++;
          $display("FAIL starve_ord: got %c want %c", g, e);
        end
      end
    end
    n_checks++;
    if (gq.size() != 0) begin
      n_fail++;
      $display("FAIL starve_tmo: %0d grants missing want 0", gq.size());
      gq.delete();
    end
    cyc();
    SB_DataValid = 1'b0;
    Lsq_ReadReq = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!Mem_En) break;
    end
    n_checks++;
    if (Mem_En !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_drain: en %b want 0", Mem_En);
    end
  endtask

  task automatic test_sb_full();
    byte g;
    byte e;
    int seen;
    seen = 0;
    gq = '{"R", "W", "R", "R", "R", "W"};
    cyc();
    SB_DataValid = 1'b1;
    Lsq_ReadReq = 1'b1;
    for (int c = 0; c < 100 && gq.size() > 0; c++) begin
      if (c != 0) cyc();
      SB_Full = (seen == 1);
      @(negedge clk);
      if (!DCE_WriteBusy || !DCE_ReadBusy) begin
        g = !DCE_WriteBusy ? "W" : "R";
        e = gq.pop_front();
        seen++;
        n_checks++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL full_ord g%0d: got %c want %c", seen, g, e);
        end
      end
    end
    n_checks++;
    if (gq.size() != 0) begin
      n_fail++;
      $display("FAIL full_tmo: %0d grants missing want 0", gq.size());
      gq.delete();
    end
    cyc();
    SB_Full = 1'b0;
    SB_DataValid = 1'b0;
    Lsq_ReadReq = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!Mem_En) break;
    end
  endtask

  task automatic test_flush();
    rexp_t r;
    int lat;
    cyc();
    Lsq_ReadReq = 1'b1;
    Lsq_ReadAddr = 32'h300;
    Lsq_ReadTag = 6'd9;
    Mem_RData = 32'h7777;
    @(negedge clk);
    n_checks++;
    if (DCE_ReadBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_accept: busy %b want 0", DCE_ReadBusy);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 1) Lsq_ReadReq = 1'b0;
      Cdb_Flush = (i == 2);
      @(negedge clk);
      n_checks++;
      if ({Mem_En, Mem_We, DCE_ReadDone} !== 3'b100) begin
        n_fail++;
        $display("FAIL fl_mem c%0d: en/we/done %b want 100",
          i, {Mem_En, Mem_We, DCE_ReadDone});
      end
    end
    cyc();
    Cdb_Flush = 1'b0;
    Lsq_ReadReq = 1'b1;
    Lsq_ReadAddr = 32'h304;
    Lsq_ReadTag = 6'd10;
    Mem_RData = 32'hCAFE;
    rq.push_back('{d: 32'hCAFE, t: 6'd10});
    @(negedge clk);
    n_checks++;
    if ({DCE_ReadDone, DCE_ReadBusy} !== 2'b00) begin
      n_fail++;
      $display("FAIL fl_c5: done/busy %b want 00",
        {DCE_ReadDone, DCE_ReadBusy});
    end
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (c == 0) Lsq_ReadReq = 1'b0;
      @(negedge clk);
      if (DCE_ReadDone) begin
        lat = c;
        break;
      end
    end
    n_checks++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL fl_next_lat: got %0d want 4", lat);
    end
    if (lat >= 0 && rq.size() > 0) begin
      r = rq.pop_front();
      n_checks++;
      if (DCE_ReadData !== r.d || DCE_ReadTag !== r.t) begin
        n_fail++;
        $display("FAIL fl_sb: got %h/%0d want %h/%0d",
          DCE_ReadData, DCE_ReadTag, r.d, r.t);
      end
    end
    rq.delete();
  endtask

  task automatic test_reset_mid_write();
    int dones;
    dones = 0;
    cyc();
    SB_DataValid = 1'b1;
    SB_AddrDmem = 32'h400;
    SB_DataDmem = 32'h55;
    @(negedge clk);
    n_checks++;
    if (DCE_WriteBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_accept: busy %b want 0", DCE_WriteBusy);
    end
    cyc();
    SB_DataValid = 1'b0;
    cyc();
    resetb = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({DCE_WriteBusy, DCE_ReadBusy, Mem_En, DCE_WriteDone} !== 4'b1100) begin
      n_fail++;
      $display("FAIL rmw_inrst: busy/busy/en/done %b want 1100",
        {DCE_WriteBusy, DCE_ReadBusy, Mem_En, DCE_WriteDone});
    end
    cyc();
    resetb = 1'b0;
    Lsq_ReadReq = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({DCE_WriteBusy, DCE_ReadBusy, Mem_En} !== 3'b100 ||
        Mem_Addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rmw_after: busy/busy/en %b a %h want 100 0",
        {DCE_WriteBusy, DCE_ReadBusy, Mem_En}, Mem_Addr);
    end
    #1;
    Lsq_ReadReq = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (DCE_WriteDone) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL rmw_nodone: %0d pulses want 0", dones);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_starvation();
    test_sb_full();
    test_flush();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Single-port data-memory controller shared by two requesters: store-buffer drain writes (committed stores) and load-queue reads (speculative loads).
- Grants one operation at a time and runs it for a fixed memory latency.
- Generates the store buffer's DCE_WriteBusy / DCE_WriteDone handshake and the load path's read completion with tag.
- Anti-starvation counter guarantees store drain when the store buffer is full or loads monopolise the port.

Parameters:
WRITE_LAT, 4, cycles a write occupies memory (>=1)
READ_LAT, 4, cycles a read occupies memory (>=1)
STARVE_MAX, 3, max consecutive read grants while a store is waiting (>=1)
TAG_W, 6, load tag width

Ports:
clk  in  1  clock, rising edge
resetb  in  1  reset, synchronous, active-high (resetb=1 resets)
SB_DataValid  in  1  store buffer head entry valid
SB_AddrDmem  in  32  store address
SB_DataDmem  in  32  store data
SB_Full  in  1  store buffer full; forces write priority
DCE_WriteBusy  out  1  0 = write accepted this cycle if SB_DataValid=1
DCE_WriteDone  out  1  one-cycle pulse, write finished in memory
Lsq_ReadReq  in  1  load read request
Lsq_ReadAddr  in  32  load address
Lsq_ReadTag  in  TAG_W  load tag
DCE_ReadBusy  out  1  0 = read accepted this cycle if Lsq_ReadReq=1
DCE_ReadDone  out  1  one-cycle pulse, DCE_ReadData/DCE_ReadTag valid
DCE_ReadData  out  32  load data
DCE_ReadTag  out  TAG_W  tag of completed load
Cdb_Flush  in  1  branch mispredict; kill in-flight or accepting read
Mem_En  out  1  memory enable
Mem_We  out  1  memory write enable
Mem_Addr  out  32  memory address (registered)
Mem_WData  out  32  memory write data (registered)
Mem_RData  in  32  memory read data, valid in last READ cycle

Behaviour:
- FSM states: IDLE, WRITE, READ. Latency counter wide enough for max(WRITE_LAT, READ_LAT). Streak counter saturates at STARVE_MAX.
- Reset (any state, including mid-operation): next state IDLE; counters 0; killed flag 0; DCE_WriteDone, DCE_ReadDone, Mem_En, Mem_We = 0; Mem_Addr, Mem_WData, DCE_ReadData, DCE_ReadTag = 0.
- While resetb=1, DCE_WriteBusy = DCE_ReadBusy = 1. The memory operation is abandoned and no Done pulse is issued.
- Grant in IDLE (combinational):
  - wgrant = SB_DataValid & (SB_Full | streak==STARVE_MAX | !Lsq_ReadReq)
  - rgrant = Lsq_ReadReq & !wgrant
- DCE_WriteBusy = !(IDLE & wgrant). DCE_ReadBusy = !(IDLE & rgrant). Both outputs are 1 in WRITE and READ.
- Write acceptance edge (IDLE & wgrant):
  - latch SB_AddrDmem / SB_DataDmem into Mem_Addr / Mem_WData; streak <= 0; go to WRITE with count = WRITE_LAT-1.
  - The store buffer shifts on this same edge.
- WRITE:
  - Mem_En = Mem_We = 1 every cycle; count decrements.
  - In the cycle with count==0, DCE_WriteDone = 1 (exactly one cycle); next state IDLE.
- Read acceptance edge (IDLE & rgrant):
  - latch Lsq_ReadAddr and Lsq_ReadTag; killed <= Cdb_Flush; go to READ with count = READ_LAT-1.
  - streak <= SB_DataValid ? sat(streak+1) : 0.
- READ:
  - Mem_En = 1, Mem_We = 0; Cdb_Flush in any READ cycle sets killed.
  - At the end of the count==0 cycle: DCE_ReadData <= Mem_RData; next state IDLE.
  - In that following IDLE cycle, DCE_ReadDone = !killed for one cycle.
- DCE_ReadDone may coincide with a new grant in the same IDLE cycle.
- Writes are never killed: Cdb_Flush has no effect on WRITE, since committed stores must complete.
- Throughput: one operation per LAT+1 cycles; no operation overlap.
- In IDLE: Mem_En = Mem_We = 0; Mem_Addr and Mem_WData hold their last values.
- Simultaneous SB_DataValid & Lsq_ReadReq with SB_Full=0 and streak<STARVE_MAX: the read wins.
- SB_DataValid=0: the streak is cleared on the next read grant.

Test Plan:
1. Write only, WRITE_LAT=4: SB_DataValid=1, addr 0x100, data 0xDEADBEEF at cycle 0 -> DCE_WriteBusy=0 in cycle 0; Mem_We=1 with those values in cycles 1-4; DCE_WriteDone pulse in cycle 4; DCE_WriteBusy=0 again in cycle 5.
2. Read only, READ_LAT=4: Lsq_ReadReq, tag 5, Mem_RData=0x1234 at cycle 4 -> DCE_ReadDone=1, DCE_ReadData=0x1234, DCE_ReadTag=5 in cycle 5 only.
3. Starvation: SB_DataValid and Lsq_ReadReq held high, SB_Full=0, STARVE_MAX=3 -> grant order R,R,R,W,R,R,R,W.
4. SB_Full=1 with both requesters active -> write granted first, streak reset to 0.
5. Cdb_Flush in cycle 2 of a read -> memory read still runs 4 cycles; DCE_ReadDone stays 0; the next request is accepted in cycle 5.
6. resetb=1 asserted in cycle 2 of a write -> DCE_WriteDone never pulses; the cycle after reset deasserts is IDLE with both busy outputs reflecting the grant logic.
